aes256_inv_key_sched: RTL and testbench

Reverse-order AES-256 round-key generator for the decryption datapath.
- Loaded with the final two round keys (rk13, rk14).
- Walks the AES-256 key schedule backwards, emitting rk14 down to rk0, one 128-bit key per valid/ready transfer.
- Sits beside the forward key-expansion logic and feeds the inverse cipher rounds.
- Uses one external 32-bit S-box instance through a combinational lookup port and generates round constants in reverse internally.

---
 rtl/aes256_inv_key_sched.sv | 114 +++++++++++
 tb/tb_aes256_inv_key_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_inv_key_sched.sv
// rtl/aes256_inv_key_sched.sv - reverse AES-256 round-key generator (rk14..rk0), one external S-box
// Optional: define AES256_INV_KEY_ROUND_IDX_EN to add the rk_round output.
module aes256_inv_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic         rk_last,
    output logic [31:0]  sub_in,
    input  logic [31:0]  sub_out
`ifdef AES256_INV_KEY_ROUND_IDX_EN
    ,
    output logic [3:0]   rk_round
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [255:0]   win;
    logic [255:0]   win_nx;
    logic [3:0]     idx;
    logic [3:0]     idx_nx;

    logic [31:0]    w_k3;
    logic [31:0]    w_k3_rot;
    logic           idx_odd;
    logic [7:0]     rcon;
    logic [31:0]    t_k4;
    logic [127:0]   new_words;

    // Window layout: win[255:224] = w[k] ... win[31:0] = w[k+7].
    assign w_k3     = win[159:128];
    assign w_k3_rot = {w_k3[23:0], w_k3[31:24]};
    assign idx_odd  = idx[0];

    // For odd idx, (idx+1)/2 - 1 equals idx[3:1], so the constant never needs GF reduction.
    assign rcon = 8'h01 << idx[3:1];
    assign t_k4 = idx_odd ? (sub_out ^ {rcon, 24'h0}) : sub_out;

    // All four previous words depend only on the current window, never on each other.
    assign new_words = {win[127:96] ^ t_k4,
                        win[95:64]  ^ win[127:96],
                        win[63:32]  ^ win[95:64],
                        win[31:0]   ^ win[63:32]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            win   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            win   <= win_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        win_nx   = win;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    win_nx   = key_in;
                    idx_nx   = 4'd14;
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx == 4'd14) begin
                        idx_nx = 4'd13;
                    end else if (idx == 4'd0) begin
                        state_nx = IDLE;
                    end else begin
                        win_nx = {new_words, win[255:128]};
                        idx_nx = idx - 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        rk_valid = 1'b0;
        rk_last  = 1'b0;
        rk_out   = '0;
        sub_in   = '0;
        if (state == EMIT) begin
            busy     = 1'b1;
            rk_valid = 1'b1;
            rk_last  = (idx == 4'd0);
            rk_out   = (idx == 4'd14) ? win[127:0] : win[255:128];
            sub_in   = idx_odd ? w_k3_rot : w_k3;
        end
    end

`ifdef AES256_INV_KEY_ROUND_IDX_EN
    assign rk_round = (state == EMIT) ? idx : 4'd0;
`endif

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// tb/tb_aes256_inv_key_sched.sv - self-checking bench for aes256_inv_key_sched
module tb_aes256_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] key_in = '0;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_out;
    logic         rk_last;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
`ifdef AES256_INV_KEY_ROUND_IDX_EN
    logic [3:0]   rk_round;
`endif

    logic [7:0]   sbox [0:255];
    logic [31:0]  w [0:59];
    logic [127:0] got [0:14];
    int           checks = 0;
    int           failures = 0;

    aes256_inv_key_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_last  (rk_last),
        .sub_in   (sub_in),
        .sub_out  (sub_out)
`ifdef AES256_INV_KEY_ROUND_IDX_EN
        ,
        .rk_round (rk_round)
`endif
    );

    always #5 clk = ~clk;

    assign sub_out = {sbox[sub_in[31:24]], sbox[sub_in[23:16]], sbox[sub_in[15:8]], sbox[sub_in[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int v = 0; v < 256; v++) begin
            b = v[7:0];
            inv = 8'h00;
            if (b != 8'h00) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, b);
            end
            sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] rotw(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    // Forward FIPS-197 expansion; the expected reverse sequence is just w[] read backwards.
    task automatic expand(input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                t = subw(rotw(t)) ^ {rc, 24'h0};
                rc = rc << 1;
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i - 8] ^ t;
        end
    endtask

    function automatic logic [127:0] rk(input int r);
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32 * i +: 32] = $urandom();
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " valid"}, rk_valid, 1'b0);
        check({tag, " last"}, rk_last, 1'b0);
        check({tag, " rk_out"}, rk_out, 128'h0);
        check({tag, " sub_in"}, sub_in, 32'h0);
`ifdef AES256_INV_KEY_ROUND_IDX_EN
        check({tag, " rk_round"}, rk_round, 4'd0);
`endif
    endtask

    // Full run with rk_ready held high; a start is pulsed on the final transfer edge.
    task automatic run_straight(input string tag);
        logic [31:0] prev_sub;
        prev_sub = '0;
        key_in = {rk(13), rk(14)};
        start = 1'b1;
        rk_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 15; n++) begin
            int id;
            id = 14 - n;
            got[n] = rk_out;
            check({tag, " valid"}, rk_valid, 1'b1);
            check({tag, " busy"}, busy, 1'b1);
            check({tag, " key"}, rk_out, rk(id));
            check({tag, " last"}, rk_last, (id == 0));
`ifdef AES256_INV_KEY_ROUND_IDX_EN
            check({tag, " rk_round"}, rk_round, id[3:0]);
`endif
            if (id <= 13)
                check({tag, " sub_in"}, sub_in, (id % 2 == 1) ? rotw(w[4 * id + 3]) : w[4 * id + 3]);
            if (id == 12)
                check({tag, " rcon13"}, rk_out[127:96] ^ w[56] ^ subw(prev_sub), 32'h40000000);
            if (id == 0)
                check({tag, " rcon1"}, rk_out[127:96] ^ w[8] ^ subw(prev_sub), 32'h01000000);
            if (n == 14) begin
                start = 1'b1;
                key_in = ~key_in;
            end
            prev_sub = sub_in;
            tick();
        end
        start = 1'b0;
        check_idle({tag, " end"});
        tick();
        check({tag, " late start ignored"}, busy, 1'b0);
    endtask

    initial begin
        logic [255:0] other;
        int n;
        int cycles;
        bit pulsed;
        bit xfer;

        build_sbox();
        repeat (3) tick();
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("post reset");

        // FIPS-197 vector
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        run_straight("vec");
        check("vec first", got[0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check("vec second", got[1], 128'h4e5a6699a9f24fe07e572baacdf8cdea);
        check("vec 14th", got[13], 128'h101112131415161718191a1b1c1d1e1f);
        check("vec 15th", got[14], 128'h000102030405060708090a0b0c0d0e0f);

        // Random key, random backpressure, start pulse while busy at idx 7
        expand(rand256());
        other = rand256();
        key_in = {rk(13), rk(14)};
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        cycles = 0;
        pulsed = 0;
        while (n < 15 && cycles < 400) begin
            rk_ready = ($urandom_range(0, 2) != 0);
            check("bp valid", rk_valid, 1'b1);
            check("bp key", rk_out, rk(14 - n));
            check("bp last", rk_last, (n == 14));
            if (n == 7 && !pulsed) begin
                start = 1'b1;
                key_in = other;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            xfer = rk_ready;
            tick();
            if (xfer) n++;
            cycles++;
        end
        start = 1'b0;
        rk_ready = 1'b0;
        check("bp completed", n, 15);
        check_idle("bp end");

        // Reset mid-sequence at idx 9, then clean restart
        expand(rand256());
        key_in = {rk(13), rk(14)};
        start = 1'b1;
        rk_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("pre-reset key", rk_out, rk(9));
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("after reset");
        expand(rand256());
        run_straight("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
